// File: rtl/contador_nbit_mod.sv
// N-bit up/down counter with runtime modulo, synchronous load, enable and clock prescaler.
// Define CONTADOR_SATURATE_EN to clamp at the range ends instead of wrapping.
module contador_nbit_mod #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] max_value,
    input  logic             clear_ovf,
    output logic [WIDTH-1:0] contador,
    output logic             tc,
    output logic             ovf
);

    // A one-bit prescaler that never leaves 0 keeps PRESCALE=1 legal without a zero-width vector.
    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic             step;
    logic             at_top;
    logic             at_zero;
    logic             range_event;
    logic [WIDTH-1:0] step_val;

    always_comb begin
        step    = en && (ps_q == PS_LAST);
        // at_top also covers a count left above a freshly lowered max_value.
        at_top  = (cnt_q >= max_value);
        at_zero = (cnt_q == '0);
        range_event = up_down ? at_top : at_zero;
`ifdef CONTADOR_SATURATE_EN
        if (up_down) step_val = at_top  ? max_value : cnt_q + WIDTH'(1);
        else         step_val = at_zero ? '0        : cnt_q - WIDTH'(1);
`else
        if (up_down) step_val = at_top  ? '0        : cnt_q + WIDTH'(1);
        else         step_val = at_zero ? max_value : cnt_q - WIDTH'(1);
`endif
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        cnt_d = cnt_q;
        ps_d  = ps_q;
        tc_d  = 1'b0;
        ovf_d = clear_ovf ? 1'b0 : ovf_q;

        if (load) begin
            cnt_d = (load_value > max_value) ? max_value : load_value;
            ps_d  = '0;
        end else if (en) begin
            if (step) begin
                ps_d  = '0;
                cnt_d = step_val;
                tc_d  = range_event;
                // A wrap or blocked step overrides a simultaneous clear.
                if (range_event) ovf_d = 1'b1;
            end else begin
                ps_d = ps_q + PS_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            ps_q  <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ps_q  <= ps_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign contador = cnt_q;
    assign tc       = tc_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_contador_nbit_mod.sv
// Bench for contador_nbit_mod: two 8-bit instances (PRESCALE 1 and 4) sharing stimulus,
// checked every cycle against a behavioural model plus directed literal expectations.
module tb_contador_nbit_mod;

`ifdef CONTADOR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up_down;
    logic       load;
    logic [7:0] load_value;
    logic [7:0] max_value;
    logic       clear_ovf;

    logic [7:0] cnt1, cnt4;
    logic       tc1, tc4, ovf1, ovf4;

    int n_checks = 0;
    int n_errors = 0;

    contador_nbit_mod #(.WIDTH(8), .PRESCALE(1)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_value(load_value), .max_value(max_value), .clear_ovf(clear_ovf),
        .contador(cnt1), .tc(tc1), .ovf(ovf1)
    );

    contador_nbit_mod #(.WIDTH(8), .PRESCALE(4)) u_dut4 (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_value(load_value), .max_value(max_value), .clear_ovf(clear_ovf),
        .contador(cnt4), .tc(tc4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: count and prescale phase tracked as plain integers per instance.
    int m_cnt[2] = '{0, 0};
    int m_ph [2] = '{0, 0};
    int m_tc [2] = '{0, 0};
    int m_ovf[2] = '{0, 0};
    int presc[2] = '{1, 4};
    bit ev;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] = 0; m_ph[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                ev = 1'b0;
                if (load) begin
                    m_cnt[k] = (int'(load_value) > int'(max_value)) ? int'(max_value) : int'(load_value);
                    m_ph[k]  = 0;
                end else if (en) begin
                    m_ph[k] = m_ph[k] + 1;
                    if (m_ph[k] == presc[k]) begin
                        m_ph[k] = 0;
                        if (up_down) begin
                            if (m_cnt[k] >= int'(max_value)) begin
                                ev = 1'b1;
                                m_cnt[k] = SAT ? int'(max_value) : 0;
                            end else m_cnt[k] = m_cnt[k] + 1;
                        end else begin
                            if (m_cnt[k] == 0) begin
                                ev = 1'b1;
                                m_cnt[k] = SAT ? 0 : int'(max_value);
                            end else m_cnt[k] = m_cnt[k] - 1;
                        end
                    end
                end
                m_tc[k] = ev ? 1 : 0;
                if (ev) m_ovf[k] = 1;
                else if (clear_ovf) m_ovf[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("model cnt p1", int'(cnt1), m_cnt[0]);
        check("model tc p1",  int'(tc1),  m_tc[0]);
        check("model ovf p1", int'(ovf1), m_ovf[0]);
        check("model cnt p4", int'(cnt4), m_cnt[1]);
        check("model tc p4",  int'(tc4),  m_tc[1]);
        check("model ovf p4", int'(ovf4), m_ovf[1]);
    end

    task automatic do_reset();
        reset = 1'b0; en = 1'b0; load = 1'b0; clear_ovf = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; up_down = 1'b1; load = 1'b0;
        load_value = 8'h00; max_value = 8'h05; clear_ovf = 1'b0;
        repeat (2) @(negedge clk);
        check("reset cnt", int'(cnt1), 0);
        check("reset tc",  int'(tc1),  0);
        check("reset ovf", int'(ovf1), 0);

        // Up count modulo 6.
        reset = 1'b1; en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("up mod6 cnt", int'(cnt1), SAT ? ((i < 5) ? i : 5) : (i % 6));
            check("up mod6 tc",  int'(tc1),  (i == 6) ? 1 : 0);
            check("up mod6 ovf", int'(ovf1), (i == 6) ? 1 : 0);
        end
        @(negedge clk);
        check("after wrap cnt", int'(cnt1), SAT ? 5 : 1);
        check("after wrap tc",  int'(tc1),  SAT ? 1 : 0);
        check("ovf sticky",     int'(ovf1), 1);
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        check("clear ovf", int'(ovf1), SAT ? 1 : 0);

        // Down from reset.
        do_reset();
        up_down = 1'b0; max_value = 8'h09; reset = 1'b1; en = 1'b1;
        @(negedge clk);
        check("down first cnt", int'(cnt1), SAT ? 0 : 9);
        check("down first tc",  int'(tc1),  1);
        @(negedge clk);
        check("down 2nd cnt", int'(cnt1), SAT ? 0 : 8);
        check("down 2nd tc",  int'(tc1),  SAT ? 1 : 0);
        @(negedge clk);
        check("down 3rd cnt", int'(cnt1), SAT ? 0 : 7);

        // Prescaler with an enable freeze in the middle.
        do_reset();
        up_down = 1'b1; max_value = 8'hFF; reset = 1'b1; en = 1'b1;
        repeat (4) @(negedge clk);
        check("presc 4 edges p4", int'(cnt4), 1);
        check("presc 4 edges p1", int'(cnt1), 4);
        repeat (2) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        check("freeze p4", int'(cnt4), 1);
        check("freeze p1", int'(cnt1), 6);
        en = 1'b1;
        repeat (6) @(negedge clk);
        check("presc 12 edges p4", int'(cnt4), 3);
        check("presc 12 edges p1", int'(cnt1), 12);

        // Load clamps to max_value and beats a step.
        max_value = 8'h20; load_value = 8'hF0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("load clamp p1", int'(cnt1), 8'h20);
        check("load clamp p4", int'(cnt4), 8'h20);
        check("load tc",       int'(tc1),  0);
        @(negedge clk);
        check("step at max cnt", int'(cnt1), SAT ? 8'h20 : 0);
        check("step at max tc",  int'(tc1),  1);
        load_value = 8'h10; load = 1'b1;
        @(negedge clk);
        check("load beats step", int'(cnt1), 8'h10);

        // Asynchronous reset mid-count.
        max_value = 8'h05; load_value = 8'h02;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        check("pre-reset cnt", int'(cnt1), 3);
        check("pre-reset ovf", int'(ovf1), 1);
        #2 reset = 1'b0;
        #1;
        check("async reset cnt", int'(cnt1), 0);
        check("async reset tc",  int'(tc1),  0);
        check("async reset ovf", int'(ovf1), 0);
        check("async reset p4",  int'(cnt4), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("resume cnt", int'(cnt1), 1);

        // max_value lowered below the current count.
        do_reset();
        reset = 1'b1; max_value = 8'h09; load_value = 8'h07; load = 1'b1;
        @(negedge clk);
        load = 1'b0; en = 1'b1; max_value = 8'h03; up_down = 1'b0;
        @(negedge clk);
        check("above max down", int'(cnt1), 6);
        check("above max down tc", int'(tc1), 0);
        up_down = 1'b1;
        @(negedge clk);
        check("above max up", int'(cnt1), SAT ? 3 : 0);
        check("above max up tc", int'(tc1), 1);

        // max_value = 0: every step is a wrap, and a wrap beats clear_ovf.
        do_reset();
        max_value = 8'h00; up_down = 1'b1; reset = 1'b1; en = 1'b1;
        @(negedge clk);
        check("max0 cnt", int'(cnt1), 0);
        check("max0 tc",  int'(tc1),  1);
        up_down = 1'b0; clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        check("max0 down tc", int'(tc1),  1);
        check("set beats clear", int'(ovf1), 1);

        // Top of 3, six up steps, clear_ovf on the sixth.
        do_reset();
        max_value = 8'h03; up_down = 1'b1; reset = 1'b1; en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) clear_ovf = 1'b1;
            @(negedge clk);
            check("top3 cnt", int'(cnt1), SAT ? ((i < 3) ? i : 3) : (i % 4));
            check("top3 tc",  int'(tc1),  SAT ? ((i >= 4) ? 1 : 0) : ((i == 4) ? 1 : 0));
        end
        clear_ovf = 1'b0;
        check("top3 ovf with clear", int'(ovf1), SAT ? 1 : 0);

        en = 1'b0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
